// File: rtl/vend_dispense_ctrl.sv
// vend_dispense_ctrl
//   Vending-machine dispense controller. Accepts one vend request at a time,
//   checks the per-slot stock, spins the slot motor for a fixed number of
//   cycles, waits (bounded) for the drop sensor and reports the outcome.
//   Stock is kept internally as sixteen 4-bit counters, restocked via load_*.
//
// Ports
//   clk          rising-edge clock
//   reset        asynchronous, active-high reset
//   req_valid    vend request present
//   req_slot     requested slot 0..15
//   req_ready    high only while IDLE (request can be accepted)
//   load_en      restock strobe, writes load_count to stock[load_slot]
//   load_slot    slot to restock
//   load_count   new stock count
//   drop_sensor  item-drop detector
//   motor_en     one-hot motor drive, nonzero only in SPIN
//   busy         high in every state except IDLE
//   done         one-cycle completion pulse
//   status       result while done=1: 00 vended, 01 empty, 10 jam
module vend_dispense_ctrl #(
    parameter int MOTOR_CYCLES   = 8,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    input  logic [3:0]  req_slot,
    output logic        req_ready,
    input  logic        load_en,
    input  logic [3:0]  load_slot,
    input  logic [3:0]  load_count,
    input  logic        drop_sensor,
    output logic [15:0] motor_en,
    output logic        busy,
    output logic        done,
    output logic [1:0]  status
);

    typedef enum logic [2:0] {
        IDLE,
        CHECK,
        SPIN,
        WAIT_DROP,
        REPORT
    } state_t;

    localparam logic [7:0] SPIN_LAST    = 8'(MOTOR_CYCLES - 1);
    localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

    localparam logic [1:0] ST_VENDED = 2'b00;
    localparam logic [1:0] ST_EMPTY  = 2'b01;
    localparam logic [1:0] ST_JAM    = 2'b10;

    state_t     state;
    logic [3:0] slot;
    logic [7:0] cnt;
    logic       dropped;
    logic [3:0] stock [16];

    logic load_ok;
    logic vend_ok;

    function automatic logic [15:0] slot_onehot(input logic [3:0] s);
        return 16'd1 << s;
    endfunction

    // A restock of the slot currently being vended is blocked so the
    // in-flight transaction sees a stable count; in IDLE every load lands,
    // including one coincident with request acceptance.
    assign load_ok = load_en && !((state != IDLE) && (load_slot == slot));

    // Successful vend: a drop seen anywhere in SPIN (including its last
    // cycle) or any drop during WAIT_DROP.
    assign vend_ok = ((state == SPIN) && (cnt == SPIN_LAST) && (dropped || drop_sensor)) ||
                     ((state == WAIT_DROP) && drop_sensor);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            slot      <= '0;
            cnt       <= '0;
            dropped   <= 1'b0;
            motor_en  <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            status    <= ST_VENDED;
            req_ready <= 1'b1;
            for (int i = 0; i < 16; i++) begin
                stock[i] <= '0;
            end
        end else begin
            // load_ok excludes the latched slot while busy, so these two
            // writes never target the same counter on one edge.
            if (load_ok) begin
                stock[load_slot] <= load_count;
            end
            if (vend_ok) begin
                stock[slot] <= stock[slot] - 4'd1;
            end

            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (req_valid) begin
                        slot      <= req_slot;
                        state     <= CHECK;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                    end
                end

                CHECK: begin
                    cnt     <= '0;
                    dropped <= 1'b0;
                    if (stock[slot] == 4'd0) begin
                        state  <= REPORT;
                        status <= ST_EMPTY;
                        done   <= 1'b1;
                    end else begin
                        state    <= SPIN;
                        motor_en <= slot_onehot(slot);
                    end
                end

                SPIN: begin
                    if (drop_sensor) begin
                        dropped <= 1'b1;
                    end
                    if (cnt == SPIN_LAST) begin
                        motor_en <= '0;
                        cnt      <= '0;
                        if (dropped || drop_sensor) begin
                            state  <= REPORT;
                            status <= ST_VENDED;
                            done   <= 1'b1;
                        end else begin
                            state <= WAIT_DROP;
                        end
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                WAIT_DROP: begin
                    // A drop on the final timeout cycle still counts as vended.
                    if (drop_sensor) begin
                        state  <= REPORT;
                        status <= ST_VENDED;
                        done   <= 1'b1;
                    end else if (cnt == TIMEOUT_LAST) begin
                        state  <= REPORT;
                        status <= ST_JAM;
                        done   <= 1'b1;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end

                REPORT: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end

                default: begin
                    state     <= IDLE;
                    motor_en  <= '0;
                    busy      <= 1'b0;
                    req_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// tb_vend_dispense_ctrl
//   Scoreboard bench for vend_dispense_ctrl. The driver plans each vend from a
//   transaction-level stock model (expected outcome and completion cycle) and
//   pushes it into a queue; an independent monitor compares busy, req_ready,
//   motor_en, done and status every cycle against the queued expectations.
module tb_vend_dispense_ctrl;

    localparam int M = 8;
    localparam int T = 32;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid = 1'b0;
    logic [3:0]  req_slot = '0;
    logic        req_ready;
    logic        load_en = 1'b0;
    logic [3:0]  load_slot = '0;
    logic [3:0]  load_count = '0;
    logic        drop_sensor = 1'b0;
    logic [15:0] motor_en;
    logic        busy;
    logic        done;
    logic [1:0]  status;

    vend_dispense_ctrl #(.MOTOR_CYCLES(M), .TIMEOUT_CYCLES(T)) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_slot(req_slot),
        .req_ready(req_ready), .load_en(load_en), .load_slot(load_slot),
        .load_count(load_count), .drop_sensor(drop_sensor), .motor_en(motor_en),
        .busy(busy), .done(done), .status(status)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [1:0] status;
        int         a;        // cycle index of CHECK
        int         done_cyc; // cycle index of REPORT
        logic [3:0] slot;
        bit         spin;
    } exp_t;

    exp_t q[$];
    int model_stock[16];
    logic [1:0] exp_last_status = 2'b00;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    // Called at a negedge with the DUT idle; returns at the negedge of the
    // first idle cycle after REPORT. mode: 0 drop in SPIN cycle k,
    // 1 drop in WAIT_DROP cycle k, 2 no drop (jam).
    task automatic do_txn(input logic [3:0] s, input bit ld, input logic [3:0] ls,
                          input logic [3:0] lc, input int mode, input int k, input bit rnd,
                          input bit bl, input logic [3:0] bl1s, input logic [3:0] bl1c,
                          input logic [3:0] bl2s, input logic [3:0] bl2c);
        int a, dcyc, dropc;
        exp_t e;
        load_en = ld; load_slot = ls; load_count = lc;
        if (ld) model_stock[ls] = int'(lc);
        req_valid = 1'b1; req_slot = s;
        drop_sensor = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
        a = cyc + 1;
        if (model_stock[s] == 0) begin
            e.status = 2'b01; e.spin = 1'b0; dcyc = a + 1; dropc = -1;
        end else begin
            e.spin = 1'b1;
            if (mode == 0) begin
                e.status = 2'b00; dropc = a + k; dcyc = a + M + 1;
            end else if (mode == 1) begin
                e.status = 2'b00; dropc = a + M + k; dcyc = a + M + k + 1;
            end else begin
                e.status = 2'b10; dropc = -1; dcyc = a + M + T + 1;
            end
            if (e.status == 2'b00) model_stock[s] = model_stock[s] - 1;
        end
        e.a = a; e.done_cyc = dcyc; e.slot = s;
        q.push_back(e);
        for (int cy = a; cy <= dcyc; cy++) begin
            @(negedge clk);
            drop_sensor = (cy == dropc) ||
                          (rnd && (cy == a || cy == dcyc) && $urandom_range(0, 1) == 1);
            load_en = 1'b0;
            if (rnd) begin
                req_valid = 1'($urandom_range(0, 1));
                req_slot  = 4'($urandom);
                if ($urandom_range(0, 3) == 0) begin
                    load_en    = 1'b1;
                    load_slot  = ($urandom_range(0, 2) == 0) ? s : 4'($urandom);
                    load_count = 4'($urandom_range(0, 3));
                end
            end else if (bl && cy == a + 2) begin
                load_en = 1'b1; load_slot = bl1s; load_count = bl1c;
            end else if (bl && cy == a + 3) begin
                load_en = 1'b1; load_slot = bl2s; load_count = bl2c;
            end
            if (load_en && load_slot != s) model_stock[load_slot] = int'(load_count);
        end
        @(negedge clk);
        drop_sensor = 1'b0;
        load_en = 1'b0;
    endtask

    task automatic idle_gap(input int n);
        for (int i = 0; i < n; i++) begin
            req_valid   = 1'b0;
            drop_sensor = 1'($urandom_range(0, 1));
            load_en     = ($urandom_range(0, 1) == 1);
            load_slot   = 4'($urandom);
            load_count  = 4'($urandom_range(0, 3));
            if (load_en) model_stock[load_slot] = int'(load_count);
            @(negedge clk);
        end
        load_en = 1'b0;
        drop_sensor = 1'b0;
    endtask

    // Monitor: sampled mid-low-phase, well away from the rising edge.
    bit         m_have, m_busy, m_done;
    logic [15:0] m_motor;
    exp_t       m_e;
    always @(negedge clk) begin
        #2;
        if (!reset) begin
            m_have = (q.size() > 0);
            if (m_have) m_e = q[0];
            m_busy  = m_have && cyc >= m_e.a && cyc <= m_e.done_cyc;
            m_motor = (m_have && m_e.spin && cyc >= m_e.a + 1 && cyc <= m_e.a + M) ?
                      (16'd1 << m_e.slot) : 16'd0;
            m_done  = m_have && cyc == m_e.done_cyc;
            check("busy", 32'(busy), 32'(m_busy));
            check("req_ready", 32'(req_ready), 32'(!m_busy));
            check("motor_en", 32'(motor_en), 32'(m_motor));
            check("done", 32'(done), 32'(m_done));
            if (m_done) exp_last_status = m_e.status;
            check("status", 32'(status), 32'(exp_last_status));
            if (m_have && cyc >= m_e.done_cyc) void'(q.pop_front());
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int a;
        exp_t e;
        for (int i = 0; i < 16; i++) model_stock[i] = 0;
        reset = 1'b0;
        #1 reset = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_motor", 32'(motor_en), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        check("rst_done", 32'(done), 32'h0);
        check("rst_status", 32'(status), 32'h0);
        check("rst_ready", 32'(req_ready), 32'h1);
        reset = 1'b0;

        // Empty slot straight after reset
        do_txn(4'd5, 0, 4'd0, 4'd0, 2, 0, 0, 0, 0, 0, 0, 0);
        // Load 3=2, drop in SPIN cycle 4, then twice more (vend, then empty)
        do_txn(4'd3, 1, 4'd3, 4'd2, 0, 4, 0, 0, 0, 0, 0, 0);
        do_txn(4'd3, 0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        do_txn(4'd3, 0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        // Load 15=1, no drop -> jam, stock kept
        do_txn(4'd15, 1, 4'd15, 4'd1, 2, 0, 0, 0, 0, 0, 0, 0);
        // Drop in WAIT_DROP cycle 10; busy loads to 15 (ignored) and 7 (applied)
        do_txn(4'd15, 0, 4'd0, 4'd0, 1, 10, 0, 1, 4'd15, 4'd9, 4'd7, 4'd1);
        do_txn(4'd15, 0, 4'd0, 4'd0, 0, 2, 0, 0, 0, 0, 0, 0);
        do_txn(4'd7, 0, 4'd0, 4'd0, 0, 8, 0, 0, 0, 0, 0, 0);
        // Drop on the very last WAIT_DROP cycle
        do_txn(4'd9, 1, 4'd9, 4'd1, 1, T, 0, 0, 0, 0, 0, 0);

        // Reset in SPIN cycle 3
        load_en = 1'b1; load_slot = 4'd2; load_count = 4'd3; model_stock[2] = 3;
        req_valid = 1'b1; req_slot = 4'd2;
        a = cyc + 1;
        e.status = 2'b00; e.a = a; e.done_cyc = a + M + T + 1; e.slot = 4'd2; e.spin = 1'b1;
        q.push_back(e);
        @(negedge clk);
        load_en = 1'b0; req_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("spin3_motor", 32'(motor_en), 32'h0004);
        reset = 1'b1;
        q.delete();
        for (int i = 0; i < 16; i++) model_stock[i] = 0;
        exp_last_status = 2'b00;
        #1;
        check("rstspin_motor", 32'(motor_en), 32'h0);
        check("rstspin_busy", 32'(busy), 32'h0);
        check("rstspin_done", 32'(done), 32'h0);
        check("rstspin_status", 32'(status), 32'h0);
        @(negedge clk);
        reset = 1'b0;
        do_txn(4'd2, 0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 0, 0, 0);
        do_txn(4'd3, 0, 4'd0, 4'd0, 0, 1, 0, 0, 0, 0, 0, 0);

        // Randomized traffic; req_valid held high between back-to-back vends
        for (int n = 0; n < 60; n++) begin
            logic [3:0] s, ls;
            int mode, k;
            s    = 4'($urandom);
            ls   = ($urandom_range(0, 1) == 1) ? s : 4'($urandom);
            mode = $urandom_range(0, 2);
            k    = (mode == 0) ? $urandom_range(1, M) : $urandom_range(1, T);
            do_txn(s, 1'($urandom_range(0, 1)), ls, 4'($urandom_range(0, 3)),
                   mode, k, 1, 0, 0, 0, 0, 0);
            if ($urandom_range(0, 3) == 0) idle_gap($urandom_range(1, 3));
        end

        req_valid = 1'b0;
        repeat (3) @(negedge clk);
        #3;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/vend_dispense_ctrl.md
VEND_DISPENSE_CTRL -- requirements
Module: vend_dispense_ctrl

Interface
REQ-001 Parameter MOTOR_CYCLES, default 8: cycles motor_en is held per vend (range 1..255).
REQ-002 Parameter TIMEOUT_CYCLES, default 32: max cycles in WAIT_DROP before jam (range 1..255).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 req_valid  input  1  vend request present.
REQ-006 req_slot  input  4  requested slot code 0..15.
REQ-007 req_ready  output  1  controller can accept a request.
REQ-008 load_en  input  1  restock write strobe.
REQ-009 load_slot  input  4  slot to restock.
REQ-010 load_count  input  4  new stock count for load_slot.
REQ-011 drop_sensor  input  1  item-drop detector, high when an item falls.
REQ-012 motor_en  output  16  one-hot slot motor drive, bit n = slot n.
REQ-013 busy  output  1  high in any state other than IDLE.
REQ-014 done  output  1  one-cycle completion pulse.
REQ-015 status  output  2  result, valid while done=1: 00 vended, 01 empty, 10 jam, 11 unused.

Function
REQ-016 FSM states SHALL be IDLE, CHECK, SPIN, WAIT_DROP, REPORT.
REQ-017 req_ready SHALL equal 1 only in IDLE; a request is accepted on an edge where req_valid & req_ready, latching req_slot and moving to CHECK.
REQ-018 Stock SHALL be held as 16 x 4-bit counters.
REQ-019 CHECK SHALL last one cycle: stock[slot]==0 -> REPORT with status 01; otherwise SPIN.
REQ-020 In SPIN, motor_en SHALL be the 4-to-16 one-hot decode of the latched slot for exactly MOTOR_CYCLES cycles, then WAIT_DROP; motor_en SHALL be all-zero in every other state.
REQ-021 drop_sensor high in any SPIN cycle SHALL set an internal dropped flag; the remaining SPIN cycles still complete.
REQ-022 WAIT_DROP SHALL be skipped (SPIN -> REPORT) if dropped is set at SPIN end.
REQ-023 In WAIT_DROP, drop_sensor=1 SHALL go to REPORT with status 00; after TIMEOUT_CYCLES cycles without drop, SHALL go to REPORT with status 10.
REQ-024 On status 00, stock[slot] SHALL decrement by 1 on the edge entering REPORT; on 01 or 10 stock SHALL be unchanged.
REQ-025 REPORT SHALL last one cycle with done=1 and status driven, then IDLE; status SHALL hold its last value at all other times.
REQ-026 load_en SHALL write load_count to stock[load_slot] on the edge, in any state, except it SHALL be ignored when busy=1 and load_slot equals the latched slot.
REQ-027 A load to the requested slot coincident with request acceptance SHALL take effect; CHECK SHALL evaluate the loaded value.
REQ-028 drop_sensor SHALL be ignored outside SPIN and WAIT_DROP.
REQ-029 Requests while busy SHALL not be accepted; req_valid may stay high and is accepted on return to IDLE.
REQ-030 Empty-slot latency: done SHALL be high in the 2nd cycle after the acceptance cycle; successful-vend latency with drop during SPIN: MOTOR_CYCLES+2 cycles.

Reset
REQ-031 reset=1 SHALL immediately force IDLE, motor_en=0, done=0, busy=0, status=00, all stock=0, counters and dropped flag=0, independent of clk.
REQ-032 Reset mid-SPIN SHALL de-energise motor_en without waiting for an edge; no stock change and no done pulse SHALL result.
REQ-033 After reset deassertion the first accept SHALL be possible on the next rising edge.

Verification
REQ-034 Reset, request slot 5 without load -> done with status 01 two cycles after acceptance, motor_en never nonzero.
REQ-035 load slot 3 = 2, request slot 3, drop_sensor pulse in SPIN cycle 4 -> motor_en=16'h0008 for exactly 8 cycles, status 00, stock[3]=1.
REQ-036 load slot 15 = 1, request 15, no drop -> motor_en=16'h8000 for 8 cycles, 32 WAIT_DROP cycles, status 10, stock[15]=1.
REQ-037 Drop in WAIT_DROP cycle 10 -> status 00 on next cycle; load_en to active slot while busy ignored, load to another slot applied.
REQ-038 Assert reset in SPIN cycle 3 -> motor_en=0 same cycle, busy=0, all stock=0, no done pulse.
REQ-039 Back-to-back: req_valid held high across two vends -> second acceptance the cycle after REPORT, req_ready low throughout busy.
